mem_port_arbiter: RTL and testbench

Shares one single-port memory between the CPU's instruction-fetch stage and its memory-access stage, so a 16-bit pipeline can run from one unified memory. Each requester uses a req/ready handshake. The arbiter runs at most one transaction at a time on the memory port. Data requests have priority, with a fetch-fairness limit. A wait timeout ensures a missing memory ack can never hang the pipeline.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusyI,
        StBusyD
    } state_e;

    typedef enum logic {
        OwnI,
        OwnD
    } owner_e;

    localparam int unsigned DefAw      = 16;
    localparam int unsigned DefDw      = 16;
    localparam int unsigned DefTimeout = 16;
    localparam int unsigned DefDStreak = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data access onto one single-port memory, one transaction at
// a time, with data priority, a fetch-fairness streak limit and an ack-wait timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW       = DefAw,
    parameter int unsigned DW       = DefDw,
    parameter int unsigned TIMEOUT  = DefTimeout,
    parameter int unsigned D_STREAK = DefDStreak
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_ready_o,
    output logic [DW-1:0] if_rdata_o,
    output logic          if_err_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic          d_ready_o,
    output logic [DW-1:0] d_rdata_o,
    output logic          d_err_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic          mem_ack_i,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          busy_o
);

    localparam int unsigned WaitW   = $clog2(TIMEOUT);
    localparam int unsigned StreakW = $clog2(D_STREAK + 1);
    localparam logic [WaitW-1:0]   WaitMax   = WaitW'(TIMEOUT - 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(D_STREAK);

    state_e              state_q, state_d;
    logic [StreakW-1:0]  streak_q, streak_d;
    logic [WaitW-1:0]    wait_q, wait_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [AW-1:0]       mem_addr_q, mem_addr_d;
    logic [DW-1:0]       mem_wdata_q, mem_wdata_d;
    logic                if_ready_q, if_ready_d;
    logic [DW-1:0]       if_rdata_q, if_rdata_d;
    logic                if_err_q, if_err_d;
    logic                d_ready_q, d_ready_d;
    logic [DW-1:0]       d_rdata_q, d_rdata_d;
    logic                d_err_q, d_err_d;

    logic                if_eff, d_eff;
    owner_e              grant_own;
    logic                done;
    logic [DW-1:0]       resp_data;
    logic                resp_err;

    // A requester's own ready cycle masks its req so a held req is taken as a fresh request.
    assign if_eff    = if_req_i & ~if_ready_q;
    assign d_eff     = d_req_i & ~d_ready_q;
    assign grant_own = (if_eff && (!d_eff || streak_q == StreakMax)) ? OwnI : OwnD;

    assign done      = mem_ack_i || (wait_q == WaitMax);
    assign resp_err  = ~mem_ack_i;
    assign resp_data = (mem_ack_i && !mem_we_q) ? mem_rdata_i : '0;

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        wait_d      = wait_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ready_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        if_err_d    = 1'b0;
        d_ready_d   = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_err_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (if_eff || d_eff) begin
                    mem_req_d = 1'b1;
                    wait_d    = '0;
                    if (grant_own == OwnI) begin
                        state_d     = StBusyI;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr_i;
                        mem_wdata_d = '0;
                        streak_d    = '0;
                    end else begin
                        state_d     = StBusyD;
                        mem_we_d    = d_we_i;
                        mem_addr_d  = d_addr_i;
                        mem_wdata_d = d_wdata_i;
                        if (!if_eff) begin
                            streak_d = '0;
                        end else if (streak_q != StreakMax) begin
                            streak_d = streak_q + 1'b1;
                        end
                    end
                end
            end
            StBusyI, StBusyD: begin
                if (done) begin
                    mem_req_d = 1'b0;
                    state_d   = StIdle;
                    if (state_q == StBusyI) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = resp_data;
                        if_err_d   = resp_err;
                    end else begin
                        d_ready_d = 1'b1;
                        d_rdata_d = resp_data;
                        d_err_d   = resp_err;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            streak_q    <= '0;
            wait_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            if_err_q    <= 1'b0;
            d_ready_q   <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            wait_q      <= wait_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            if_rdata_q  <= if_rdata_d;
            if_err_q    <= if_err_d;
            d_ready_q   <= d_ready_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
        end
    end

    assign if_ready_o  = if_ready_q;
    assign if_rdata_o  = if_rdata_q;
    assign if_err_o    = if_err_q;
    assign d_ready_o   = d_ready_q;
    assign d_rdata_o   = d_rdata_q;
    assign d_err_o     = d_err_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model and a
// latency-programmable memory responder.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned TO = 16;
    localparam int unsigned DS = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ready;
    logic [DW-1:0] if_rdata;
    logic          if_err;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          d_err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;

    int checks = 0;
    int errors = 0;

    // Responder controls: latency in cycles after mem_req rises (-1 = never ack).
    int lat_cfg = 0;
    bit spur = 1'b0;
    int rcnt = 0;
    bit [15:0] rmem [256];

    // Reference model state.
    bit [15:0] ref_mem [256];
    int m_streak = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .TIMEOUT(TO), .D_STREAK(DS)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr),
        .if_ready_o(if_ready), .if_rdata_o(if_rdata), .if_err_o(if_err),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_ready_o(d_ready), .d_rdata_o(d_rdata), .d_err_o(d_err),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
        .busy_o(busy)
    );

    always @(negedge clk) begin
        if (mem_ack) begin
            mem_ack <= 1'b0;
            rcnt    <= 0;
        end else if (mem_req) begin
            if (lat_cfg >= 0 && rcnt == lat_cfg) begin
                mem_ack <= 1'b1;
                if (mem_we) begin
                    rmem[mem_addr[7:0]] <= mem_wdata;
                    mem_rdata <= 16'($urandom);
                end else begin
                    mem_rdata <= rmem[mem_addr[7:0]];
                end
            end
            rcnt <= rcnt + 1;
        end else begin
            rcnt      <= 0;
            mem_ack   <= spur;
            mem_rdata <= 16'($urandom);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pick_fetch(input bit ei, input bit ed, input int s);
        return ei && (!ed || s == int'(DS));
    endfunction

    task automatic upd_streak(input bit fetch, input bit ei);
        if (fetch || !ei) m_streak = 0;
        else if (m_streak < int'(DS)) m_streak = m_streak + 1;
    endtask

    // who: 0 = fetch, 1 = data, -1 = nothing within the bound.
    task automatic wait_ready(output int who, output int n);
        who = -1;
        n = 0;
        while (who < 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (if_ready) who = 0;
            else if (d_ready) who = 1;
        end
    endtask

    // One isolated transaction from one requester; called and returns at a negedge.
    task automatic do_txn(input bit is_d, input bit we, input logic [15:0] addr,
                          input logic [15:0] wdata, input int lat);
        int n, exp_lat;
        bit got, exp_err, unstable, stray, rdy;
        logic [15:0] exp_rd, other_rd, cap_addr, cap_wdata;
        logic cap_we;
        exp_err = (lat < 0) || (lat > int'(TO) - 1);
        exp_lat = exp_err ? int'(TO) + 1 : lat + 2;
        exp_rd = (exp_err || (is_d && we)) ? 16'h0 : ref_mem[addr[7:0]];
        other_rd = is_d ? if_rdata : d_rdata;
        lat_cfg = lat;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
            if_addr = 16'($urandom);
        end else begin
            if_req = 1'b1; if_addr = addr;
            d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
        end
        upd_streak(!is_d, 1'b0);
        got = 0; n = 0; unstable = 0; stray = 0;
        cap_addr = '0; cap_wdata = '0; cap_we = 1'b0;
        while (!got && n < int'(TO) + 8) begin
            @(negedge clk);
            n++;
            rdy = is_d ? d_ready : if_ready;
            if (n == 1) begin
                chk("busy_after_grant", busy, 1);
                chk("mem_req_after_grant", mem_req, 1);
                chk("mem_addr", mem_addr, addr);
                chk("mem_we", mem_we, is_d ? we : 1'b0);
                if (is_d && we) chk("mem_wdata", mem_wdata, wdata);
                cap_addr = mem_addr; cap_wdata = mem_wdata; cap_we = mem_we;
            end else if (!rdy && (mem_req !== 1'b1 || mem_addr !== cap_addr ||
                                  mem_we !== cap_we || mem_wdata !== cap_wdata)) begin
                unstable = 1;
            end
            if (is_d ? if_ready : d_ready) stray = 1;
            if (!rdy && (if_err || d_err)) stray = 1;
            if (rdy) got = 1;
        end
        chk("latency", n, exp_lat);
        chk("err", is_d ? d_err : if_err, exp_err);
        chk("rdata", is_d ? d_rdata : if_rdata, exp_rd);
        chk("mem_req_dropped", mem_req, 0);
        chk("other_rdata_hold", is_d ? if_rdata : d_rdata, other_rd);
        chk("mem_port_stable", unstable, 0);
        chk("no_stray_ready_err", stray, 0);
        if (is_d) d_req = 1'b0; else if_req = 1'b0;
        if (got && !exp_err && is_d && we) ref_mem[addr[7:0]] = wdata;
        @(negedge clk);
        chk("pulse_end", {if_ready, d_ready, if_err, d_err}, 0);
        chk("idle_after", busy, 0);
    endtask

    // Both requesters hold req continuously with a zero-latency memory.
    task automatic contention(input int num);
        int who, n, g, last;
        bit ei, ed;
        lat_cfg = 0; last = -1;
        if_addr = 16'h0040; d_addr = 16'h0010; d_we = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < num; k++) begin
            ei = (last != 0);
            ed = (last != 1);
            g = pick_fetch(ei, ed, m_streak) ? 0 : 1;
            upd_streak(g == 0, ei);
            wait_ready(who, n);
            chk("cont_who", who, g);
            chk("cont_gap", n, 2);
            chk("cont_rdata", (g == 0) ? if_rdata : d_rdata,
                (g == 0) ? ref_mem[8'h40] : ref_mem[8'h10]);
            last = g;
        end
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("cont_idle", busy, 0);
    endtask

    // Data alone, req held through its ready cycles: each ready masks one cycle.
    task automatic same_req_b2b();
        int who, n;
        lat_cfg = 0;
        d_addr = 16'h0010; d_we = 1'b0; d_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            upd_streak(1'b0, 1'b0);
            wait_ready(who, n);
            chk("b2b_who", who, 1);
            chk("b2b_gap", n, (k == 0) ? 2 : 3);
        end
        d_req = 1'b0;
        @(negedge clk);
    endtask

    // Fetch is raised with each data request but withdrawn after losing, building the streak.
    task automatic streak_test();
        int who, n, g;
        lat_cfg = 1;
        if_addr = 16'h0040; d_addr = 16'h0010; d_we = 1'b0;
        for (int k = 0; k <= int'(DS); k++) begin
            if_req = 1'b1; d_req = 1'b1;
            g = pick_fetch(1'b1, 1'b1, m_streak) ? 0 : 1;
            upd_streak(g == 0, 1'b1);
            @(negedge clk);
            if (g == 1) if_req = 1'b0;
            wait_ready(who, n);
            chk("streak_who", who, g);
            chk("streak_lat", n + 1, 3);
            if (g == 0) begin
                if_req = 1'b0;
                upd_streak(1'b0, 1'b0);
                wait_ready(who, n);
                chk("streak_after_fetch", who, 1);
            end
            d_req = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int who, n, r, lat;
        bit flag;
        logic [15:0] a;

        @(negedge clk);
        chk("reset_outputs", {if_ready, if_rdata, if_err, d_ready, d_rdata, d_err,
                              mem_req, mem_we, mem_addr, mem_wdata, busy}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_txn(1'b1, 1'b1, 16'h0040, 16'h7000, 1);
        do_txn(1'b0, 1'b0, 16'h0040, 16'h0000, 3);
        do_txn(1'b1, 1'b1, 16'h0010, 16'hBEEF, 2);
        do_txn(1'b1, 1'b0, 16'h0010, 16'h0000, 0);
        do_txn(1'b1, 1'b0, 16'h0010, 16'h0000, -1);
        do_txn(1'b1, 1'b0, 16'h0040, 16'h0000, 1);
        do_txn(1'b0, 1'b0, 16'h0010, 16'h0000, int'(TO) - 1);
        do_txn(1'b1, 1'b0, 16'h0040, 16'h0000, int'(TO) - 1);
        do_txn(1'b0, 1'b0, 16'h0010, 16'h0000, int'(TO));

        spur = 1'b1;
        flag = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (busy || mem_req || if_ready || d_ready) flag = 1;
        end
        spur = 1'b0;
        chk("idle_ack_ignored", flag, 0);
        @(negedge clk);
        @(negedge clk);

        same_req_b2b();
        contention(10);
        streak_test();

        for (int t = 0; t < 40; t++) begin
            r = int'($urandom_range(0, 9));
            lat = (r < 7) ? int'($urandom_range(0, 4)) : ((r == 7) ? int'(TO) - 1 :
                  ((r == 8) ? int'(TO) : -1));
            a = {12'h0, 4'($urandom)};
            do_txn(1'($urandom), 1'($urandom), a, 16'($urandom), lat);
        end

        lat_cfg = -1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0055; d_wdata = 16'h1234;
        for (int k = 0; k < 4; k++) @(negedge clk);
        chk("pre_reset_busy", {busy, mem_req}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_drop", {busy, mem_req}, 0);
        chk("async_reset_outputs", {if_ready, if_rdata, if_err, d_ready, d_rdata, d_err,
                                    mem_we, mem_addr, mem_wdata}, 0);
        @(negedge clk);
        d_req = 1'b0;
        flag = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (d_ready) flag = 1;
        end
        chk("no_ready_after_reset", flag, 0);
        rst_n = 1'b1;
        m_streak = 0;
        @(negedge clk);
        do_txn(1'b0, 1'b0, 16'h0040, 16'h0000, 2);
        do_txn(1'b1, 1'b0, 16'h0055, 16'h0000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
